// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core.
// MULT/DIV results are computed at issue into shadow registers and committed after a fixed latency.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [WIDTH-1:0]  hi_n, lo_n;
    logic [WIDTH-1:0]  shadow_hi, shadow_hi_n;
    logic [WIDTH-1:0]  shadow_lo, shadow_lo_n;

    // Datapath: all four results are formed combinationally from the live operands.
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag, b_mag_safe, b_safe;
    logic [WIDTH-1:0]   quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;

    assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    // Signed divide through magnitudes: the most-negative dividend has a representable
    // unsigned magnitude, so most-negative / -1 wraps back to most-negative with remainder 0.
    assign a_neg      = A[WIDTH-1];
    assign b_neg      = B[WIDTH-1];
    assign b_zero     = (B == '0);
    assign a_mag      = a_neg ? (~A + 1'b1) : A;
    assign b_mag      = b_neg ? (~B + 1'b1) : B;
    assign b_mag_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign b_safe     = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : B;
    assign quo_mag    = a_mag / b_mag_safe;
    assign rem_mag    = a_mag % b_mag_safe;
    assign quo_s      = (a_neg ^ b_neg) ? (~quo_mag + 1'b1) : quo_mag;
    assign rem_s      = a_neg ? (~rem_mag + 1'b1) : rem_mag;
    assign quo_u      = A / b_safe;
    assign rem_u      = A % b_safe;

    // Handshake: op/A/B are accepted on a rising edge with start=1 and busy=0; start while
    // busy=1 is dropped, and the result is visible on hi/lo in the first cycle busy is low again.
    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            shadow_hi <= '0;
            shadow_lo <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            hi        <= hi_n;
            lo        <= lo_n;
            shadow_hi <= shadow_hi_n;
            shadow_lo <= shadow_lo_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hi_n        = hi;
        lo_n        = lo;
        shadow_hi_n = shadow_hi;
        shadow_lo_n = shadow_lo;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            {shadow_hi_n, shadow_lo_n} = prod_s;
                            cnt_n   = CW'(MULT_CYCLES);
                            state_n = RUN;
                        end
                        OP_MULTU: begin
                            {shadow_hi_n, shadow_lo_n} = prod_u;
                            cnt_n   = CW'(MULT_CYCLES);
                            state_n = RUN;
                        end
                        OP_DIV: begin
                            // Divide by zero commits the current hi/lo, i.e. leaves them unchanged.
                            shadow_hi_n = b_zero ? hi : rem_s;
                            shadow_lo_n = b_zero ? lo : quo_s;
                            cnt_n       = CW'(DIV_CYCLES);
                            state_n     = RUN;
                        end
                        OP_DIVU: begin
                            shadow_hi_n = b_zero ? hi : rem_u;
                            shadow_lo_n = b_zero ? lo : quo_u;
                            cnt_n       = CW'(DIV_CYCLES);
                            state_n     = RUN;
                        end
                        OP_MTHI: hi_n = A;
                        OP_MTLO: lo_n = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    hi_n    = shadow_hi;
                    lo_n    = shadow_lo;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a default 32-bit instance and a 16-bit single-cycle instance.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    logic        start16;
    logic [2:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16;
    logic [15:0] hi16, lo16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .hi(hi), .lo(lo)
    );

    md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .A(a16), .B(b16),
        .busy(busy16), .hi(hi16), .lo(lo16)
    );

    // Issue one op on the 32-bit unit and count the cycles busy stays high.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int nb);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy && nb < 50) begin
            nb++;
            @(negedge clk);
        end
    endtask

    task automatic issue16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                           output int nb);
        @(negedge clk);
        start16 = 1'b1; op16 = o; a16 = x; b16 = y;
        @(negedge clk);
        start16 = 1'b0;
        nb = 0;
        while (busy16 && nb < 50) begin
            nb++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int nb;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_cmp++; if (busy16 !== 1'b0 || hi16 !== 16'h0 || lo16 !== 16'h0) begin
            n_err++; $display("FAIL reset16: got busy=%b hi=%h lo=%h want 0/0/0", busy16, hi16, lo16);
        end
        issue(3'd4, 32'h1234, 32'h0, nb);
        n_cmp++; if (nb !== 0) begin n_err++; $display("FAIL mthi_busy: got %0d cycles want 0", nb); end
        n_cmp++; if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi_hi: got %h want 00001234", hi); end
    endtask

    task automatic test_mult;
        int nb;
        issue(3'd0, 32'hFFFF_FFFD, 32'd7, nb);
        n_cmp++; if (nb !== 5) begin n_err++; $display("FAIL mult_busy: got %0d want 5", nb); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
        issue(3'd1, 32'hFFFF_FFFD, 32'd7, nb);
        n_cmp++; if (nb !== 5) begin n_err++; $display("FAIL multu_busy: got %0d want 5", nb); end
        n_cmp++; if (hi !== 32'h6) begin n_err++; $display("FAIL multu_hi: got %h want 00000006", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL multu_lo: got %h want ffffffeb", lo); end
    endtask

    task automatic test_div;
        int nb;
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, nb);
        n_cmp++; if (nb !== 10) begin n_err++; $display("FAIL div_busy: got %0d want 10", nb); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        issue(3'd3, 32'd7, 32'd2, nb);
        n_cmp++; if (nb !== 10) begin n_err++; $display("FAIL divu_busy: got %0d want 10", nb); end
        n_cmp++; if (lo !== 32'd3) begin n_err++; $display("FAIL divu_lo: got %h want 00000003", lo); end
        n_cmp++; if (hi !== 32'd1) begin n_err++; $display("FAIL divu_hi: got %h want 00000001", hi); end
    endtask

    task automatic test_div_corner;
        int nb;
        issue(3'd4, 32'd9, 32'd0, nb);
        issue(3'd5, 32'd5, 32'd0, nb);
        issue(3'd3, 32'd123, 32'd0, nb);
        n_cmp++; if (nb !== 10) begin n_err++; $display("FAIL divzero_busy: got %0d want 10", nb); end
        n_cmp++; if (lo !== 32'd5) begin n_err++; $display("FAIL divzero_lo: got %h want 00000005", lo); end
        n_cmp++; if (hi !== 32'd9) begin n_err++; $display("FAIL divzero_hi: got %h want 00000009", hi); end
        issue(3'd6, 32'hAAAA_AAAA, 32'd3, nb);
        n_cmp++; if (nb !== 0 || hi !== 32'd9 || lo !== 32'd5) begin
            n_err++; $display("FAIL reserved_op: got busy=%0d hi=%h lo=%h want 0/9/5", nb, hi, lo);
        end
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb);
        n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL divovf_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_busy_ignore;
        int nb;
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFD; b = 32'd7;
        @(negedge clk);
        nb = busy ? 1 : 0;
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
        @(negedge clk);
        if (busy) nb++;
        start = 1'b1; op = 3'd5; a = 32'h0000_DEAD; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        while (busy && nb < 50) begin
            nb++;
            @(negedge clk);
        end
        n_cmp++; if (nb !== 5) begin n_err++; $display("FAIL ignore_busy: got %0d want 5", nb); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ignore_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL ignore_lo: got %h want ffffffeb", lo); end
        repeat (12) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || lo !== 32'hFFFF_FFEB || hi !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL ignore_late: got busy=%b hi=%h lo=%h want 0/ffffffff/ffffffeb", busy, hi, lo);
        end
    endtask

    task automatic test_reset_abort;
        int nb;
        int late;
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy && nb < 4) begin
            nb++;
            if (nb < 4) @(negedge clk);
        end
        n_cmp++; if (nb !== 4) begin n_err++; $display("FAIL abort_pre: got %0d busy cycles want 4", nb); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_err++; $display("FAIL abort_reset: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
        late = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) late++;
        end
        n_cmp++; if (late !== 0) begin n_err++; $display("FAIL abort_commit: got %0d bad cycles want 0", late); end
    endtask

    task automatic test_short;
        int nb;
        issue16(3'd0, 16'hFFFD, 16'd7, nb);
        n_cmp++; if (nb !== 1 || hi16 !== 16'hFFFF || lo16 !== 16'hFFEB) begin
            n_err++; $display("FAIL w16_mult: got busy=%0d hi=%h lo=%h want 1/ffff/ffeb", nb, hi16, lo16);
        end
        issue16(3'd1, 16'hFFFD, 16'd7, nb);
        n_cmp++; if (nb !== 1 || hi16 !== 16'h0006 || lo16 !== 16'hFFEB) begin
            n_err++; $display("FAIL w16_multu: got busy=%0d hi=%h lo=%h want 1/0006/ffeb", nb, hi16, lo16);
        end
        issue16(3'd2, 16'hFFF9, 16'd2, nb);
        n_cmp++; if (nb !== 1 || hi16 !== 16'hFFFF || lo16 !== 16'hFFFD) begin
            n_err++; $display("FAIL w16_div: got busy=%0d hi=%h lo=%h want 1/ffff/fffd", nb, hi16, lo16);
        end
        issue16(3'd3, 16'd7, 16'd2, nb);
        n_cmp++; if (nb !== 1 || hi16 !== 16'd1 || lo16 !== 16'd3) begin
            n_err++; $display("FAIL w16_divu: got busy=%0d hi=%h lo=%h want 1/0001/0003", nb, hi16, lo16);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; op = 3'd0; a = '0; b = '0;
        start16 = 1'b0; op16 = 3'd0; a16 = '0; b16 = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_corner();
        test_busy_ignore();
        test_reset_abort();
        test_short();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
